// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 opcodes,
// FSM state encoding and small opcode-decoding helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  // Divide-family opcodes (DIV/DIVU/REM/REMU).
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  // Remainder opcodes (REM/REMU).
  function automatic logic is_rem(input logic [2:0] f);
    return f[2] & f[1];
  endfunction

  // SrcA is a signed operand. MUL is treated as unsigned: its low half is
  // identical either way, so no sign handling is needed for it.
  function automatic logic is_signed_a(input logic [2:0] f);
    return (f == MDU_MULH) || (f == MDU_MULHSU) || (f == MDU_DIV) || (f == MDU_REM);
  endfunction

  // SrcB is a signed operand.
  function automatic logic is_signed_b(input logic [2:0] f);
    return (f == MDU_MULH) || (f == MDU_DIV) || (f == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore result signs after the unsigned iteration.
module mdu_abs_neg #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] value,
  input  logic              neg,
  output logic [DATA_W-1:0] result
);

  // Negate when requested, otherwise pass through.
  always_comb begin
    result = neg ? (DATA_W'(0) - value) : value;
  end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M-style multiply/divide unit, radix-2 (one bit per cycle).
// Multiply is shift-add on operand magnitudes; divide is restoring division.
// Build option: define MDU_EARLY_OUT_EN to let divide-by-zero, signed divide
// overflow and any zero operand finish one cycle after accept instead of
// running the full XLEN+2 cycle sequence. Results are identical either way.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] MDU_result,
  output logic            zero
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t state, state_next;
  logic [CNT_W-1:0] cnt;

  // Operation context captured on accept.
  logic [2:0]      op;
  logic            sign_q;     // sign of product / quotient
  logic            sign_r;     // sign of remainder
  logic            force_en;   // special case: result comes from force_val
  logic [XLEN-1:0] force_val;

  // Shared iteration registers.
  // Multiply: {hi, lo} is the running product, lo starts as the multiplier,
  //           opb holds the multiplicand.
  // Divide:   hi is the partial remainder, lo shifts the dividend out and the
  //           quotient in, opb holds the divisor.
  logic [XLEN-1:0] hi, lo, opb;

  logic            accept;
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, early;
  logic [XLEN-1:0] special_val;

  logic [XLEN:0]   mul_sum, div_shift, div_diff;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_val;

  // ---------------------------------------------------------------------
  // Accept-time operand conditioning
  // ---------------------------------------------------------------------
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign sgn_a  = is_signed_a(funct3) & SrcA[XLEN-1];
  assign sgn_b  = is_signed_b(funct3) & SrcB[XLEN-1];

  mdu_abs_neg #(.DATA_W(XLEN)) u_mag_a (.value(SrcA), .neg(sgn_a), .result(mag_a));
  mdu_abs_neg #(.DATA_W(XLEN)) u_mag_b (.value(SrcB), .neg(sgn_b), .result(mag_b));

  // Special-case detection and the value each special case must produce.
  always_comb begin
    div_zero    = is_div(funct3) && (SrcB == '0);
    div_ovf     = ((funct3 == MDU_DIV) || (funct3 == MDU_REM)) &&
                  (SrcA == MIN_NEG) && (SrcB == '1);
    special_val = '0;
    if (div_zero) begin
      special_val = is_rem(funct3) ? SrcA : '1;
    end else if (div_ovf) begin
      special_val = is_rem(funct3) ? '0 : SrcA;
    end
`ifdef MDU_EARLY_OUT_EN
    // A zero operand always yields zero (quotient and remainder of 0/x are 0,
    // x/0 is already covered by div_zero above).
    early = div_zero | div_ovf | (SrcA == '0) | (SrcB == '0);
`else
    early = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------
  // FSM: next state and status outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = early ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == LAST_ITER) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = early ? DONE : CALC;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Iteration step (one bit per CALC cycle)
  // ---------------------------------------------------------------------
  // Multiply adds the multiplicand when the current multiplier bit is set.
  // Divide shifts the next dividend bit into the remainder and tries a
  // subtraction; a borrow (top bit set) means the quotient bit is 0.
  always_comb begin
    mul_sum   = {1'b0, hi} + {1'b0, opb & {XLEN{lo[0]}}};
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
  end

  // Datapath registers: loaded on accept, stepped while in CALC.
  always_ff @(posedge clk) begin
    if (accept) begin
      op        <= funct3;
      hi        <= '0;
      lo        <= is_div(funct3) ? mag_a : mag_b;
      opb       <= is_div(funct3) ? mag_b : mag_a;
      sign_q    <= sgn_a ^ sgn_b;
      sign_r    <= sgn_a;
      force_en  <= div_zero | div_ovf;
      force_val <= special_val;
    end else if (state == CALC) begin
      if (is_div(op)) begin
        if (!div_diff[XLEN]) begin
          hi <= div_diff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= div_shift[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIX: sign restore and result selection
  // ---------------------------------------------------------------------
  mdu_abs_neg #(.DATA_W(2*XLEN)) u_neg_prod (.value({hi, lo}), .neg(sign_q), .result(prod));
  mdu_abs_neg #(.DATA_W(XLEN))   u_neg_quo  (.value(lo),       .neg(sign_q), .result(quo));
  mdu_abs_neg #(.DATA_W(XLEN))   u_neg_rem  (.value(hi),       .neg(sign_r), .result(rem));

  // Pick the final value for the captured opcode; special cases override.
  always_comb begin
    if (force_en) begin
      fix_val = force_val;
    end else if (is_div(op)) begin
      fix_val = is_rem(op) ? rem : quo;
    end else if (op == MDU_MUL) begin
      fix_val = prod[XLEN-1:0];
    end else begin
      fix_val = prod[2*XLEN-1:XLEN];
    end
  end

  // Control state, iteration counter and the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      MDU_result <= '0;
      zero       <= 1'b1;
    end else begin
      state <= state_next;
      if (accept || (state != CALC)) cnt <= '0;
      else                           cnt <= cnt + CNT_W'(1);
      if (accept && early) begin
        MDU_result <= special_val;
        zero       <= (special_val == '0);
      end else if (state == FIX) begin
        MDU_result <= fix_val;
        zero       <= (fix_val == '0);
      end
    end
  end

endmodule
